// File: rtl/alu_acc_pkg.sv
// rtl/alu_acc_pkg.sv - shared widths, opcodes and FSM state type for the accumulator ALU
package alu_acc_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 2;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic is_zero(input data_t v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/alu_acc_if.sv
// rtl/alu_acc_if.sv - command/result handshake bundle; master drives commands, slave is the controller
interface alu_acc_if;
  import alu_acc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_carry;

  modport master (
    output in_valid, in_op, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carry
  );

  modport slave (
    input  in_valid, in_op, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carry
  );

endinterface

// File: rtl/alu4_exec.sv
// rtl/alu4_exec.sv - combinational 4-bit accumulator datapath
// ALU_ACC_CARRY_EN: when defined, ADD reports its carry-out; otherwise carry is tied low.
module alu4_exec
  import alu_acc_pkg::*;
(
  input  data_t acc,
  input  data_t b,
  input  op_e   op,
  output data_t next_acc,
  output logic  carry
);

  data_t sum_lo;
  logic  carry_add;

`ifdef ALU_ACC_CARRY_EN
  logic [DATA_W:0] sum;
  assign sum       = {1'b0, acc} + {1'b0, b};
  assign sum_lo    = sum[DATA_W-1:0];
  assign carry_add = sum[DATA_W];
`else
  assign sum_lo    = acc + b;
  assign carry_add = 1'b0;
`endif

  // carry only survives an ADD; every other opcode clears it
  always_comb begin
    next_acc = acc;
    carry    = 1'b0;
    case (op)
      OP_ADD: begin
        next_acc = sum_lo;
        carry    = carry_add;
      end
      OP_AND:  next_acc = acc & b;
      OP_LOAD: next_acc = b;
      OP_CLR:  next_acc = '0;
      default: next_acc = acc;
    endcase
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// rtl/alu_acc_ctrl.sv - IDLE/EXEC/RESP controller owning the accumulator and registered result
// ALU_ACC_CARRY_EN selects whether out_carry reflects the ADD carry-out (see alu4_exec).
module alu_acc_ctrl
  import alu_acc_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  alu_acc_if.slave bus
);

  state_e state;
  data_t  acc;
  data_t  b_q;
  op_e    op_q;
  data_t  next_acc;
  logic   carry;

  data_t  result_q;
  logic   zero_q;
  logic   carry_q;
  logic   in_ready_q;
  logic   out_valid_q;

  alu4_exec u_exec (
    .acc      (acc),
    .b        (b_q),
    .op       (op_q),
    .next_acc (next_acc),
    .carry    (carry)
  );

  // handshake outputs are registered alongside the state so they never glitch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_q       <= op_e'(bus.in_op);
            b_q        <= bus.in_b;
            in_ready_q <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          acc         <= next_acc;
          result_q    <= next_acc;
          zero_q      <= is_zero(next_acc);
          carry_q     <= carry;
          out_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_carry  = carry_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb/tb_alu_acc_ctrl.sv - directed table-driven bench for alu_acc_ctrl
module tb_alu_acc_ctrl;
  import alu_acc_pkg::*;

`ifdef ALU_ACC_CARRY_EN
  localparam logic CARRY_ON = 1'b1;
`else
  localparam logic CARRY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_acc_if bus ();

  alu_acc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] b;
    logic [3:0] res;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) check1({name, " ready timeout"}, bus.in_ready, 1'b1);
  endtask

  // one full command from IDLE with out_ready high; called and returns at a negedge
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] b,
                         input logic [3:0] res, input logic z, input logic c);
    wait_ready(name);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_b      = b;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op    = OP_CLR;
    bus.in_b     = 4'hF;
    check1({name, " exec out_valid"}, bus.out_valid, 1'b0);
    check1({name, " exec in_ready"}, bus.in_ready, 1'b0);
    @(negedge clk);
    check1({name, " resp out_valid"}, bus.out_valid, 1'b1);
    check4({name, " result"}, bus.out_result, res);
    check1({name, " zero"}, bus.out_zero, z);
    check1({name, " carry"}, bus.out_carry, c);
    @(negedge clk);
    check1({name, " back idle in_ready"}, bus.in_ready, 1'b1);
    check1({name, " back idle out_valid"}, bus.out_valid, 1'b0);
  endtask

  logic [1:0] bops [6];
  logic [3:0] bbs  [6];
  logic [3:0] bexp [6];

  initial begin
    vecs[0]  = '{OP_LOAD, 4'h5, 4'h5, 1'b0, 1'b0};
    vecs[1]  = '{OP_LOAD, 4'hC, 4'hC, 1'b0, 1'b0};
    vecs[2]  = '{OP_ADD,  4'h7, 4'h3, 1'b0, 1'b1};
    vecs[3]  = '{OP_LOAD, 4'hA, 4'hA, 1'b0, 1'b0};
    vecs[4]  = '{OP_AND,  4'h6, 4'h2, 1'b0, 1'b0};
    vecs[5]  = '{OP_CLR,  4'h9, 4'h0, 1'b1, 1'b0};
    vecs[6]  = '{OP_ADD,  4'hF, 4'hF, 1'b0, 1'b0};
    vecs[7]  = '{OP_ADD,  4'h1, 4'h0, 1'b1, 1'b1};
    vecs[8]  = '{OP_AND,  4'h0, 4'h0, 1'b1, 1'b0};
    vecs[9]  = '{OP_LOAD, 4'h8, 4'h8, 1'b0, 1'b0};
    vecs[10] = '{OP_ADD,  4'h8, 4'h0, 1'b1, 1'b1};
    vecs[11] = '{OP_ADD,  4'h3, 4'h3, 1'b0, 1'b0};

    bops[0] = OP_LOAD; bbs[0] = 4'h1; bexp[0] = 4'h1;
    bops[1] = OP_ADD;  bbs[1] = 4'h2; bexp[1] = 4'h3;
    bops[2] = OP_ADD;  bbs[2] = 4'h4; bexp[2] = 4'h7;
    bops[3] = OP_AND;  bbs[3] = 4'h5; bexp[3] = 4'h5;
    bops[4] = OP_ADD;  bbs[4] = 4'hB; bexp[4] = 4'h0;
    bops[5] = OP_LOAD; bbs[5] = 4'hE; bexp[5] = 4'hE;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_b      = 4'h0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check1("reset in_ready", bus.in_ready, 1'b1);
    check1("reset out_valid", bus.out_valid, 1'b0);
    check4("reset result", bus.out_result, 4'h0);
    check1("reset zero", bus.out_zero, 1'b1);
    check1("reset carry", bus.out_carry, 1'b0);

    for (int i = 0; i < 12; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].b, vecs[i].res, vecs[i].z,
              vecs[i].c & CARRY_ON);

    // stall in RESP while the producer keeps offering junk commands
    wait_ready("hold");
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_LOAD;
    bus.in_b      = 4'h9;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = 2'(i + 1);
      bus.in_b     = 4'(15 - i);
      @(negedge clk);
      check1($sformatf("hold%0d out_valid", i), bus.out_valid, 1'b1);
      check4($sformatf("hold%0d result", i), bus.out_result, 4'h9);
      check1($sformatf("hold%0d zero", i), bus.out_zero, 1'b0);
      check1($sformatf("hold%0d in_ready", i), bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check1("hold release out_valid", bus.out_valid, 1'b0);
    check1("hold release in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    check1("hold no capture in_ready", bus.in_ready, 1'b1);
    check1("hold no capture out_valid", bus.out_valid, 1'b0);
    run_cmd("hold acc kept", OP_ADD, 4'h0, 4'h9, 1'b0, 1'b0);

    // reset while ADD is in EXEC
    run_cmd("pre rst load", OP_LOAD, 4'h7, 4'h7, 1'b0, 1'b0);
    wait_ready("rst exec");
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_b     = 4'h1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check1("rst exec out_valid", bus.out_valid, 1'b0);
    check1("rst exec in_ready", bus.in_ready, 1'b1);
    check4("rst exec result", bus.out_result, 4'h0);
    check1("rst exec zero", bus.out_zero, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1($sformatf("rst exec quiet%0d", i), bus.out_valid, 1'b0);
    end
    run_cmd("post rst add", OP_ADD, 4'h1, 4'h1, 1'b0, 1'b0);

    // reset during RESP with out_ready and in_valid high at the same edge
    wait_ready("rst resp");
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_LOAD;
    bus.in_b      = 4'h3;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check1("rst resp pre out_valid", bus.out_valid, 1'b1);
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    check1("rst resp out_valid", bus.out_valid, 1'b0);
    check1("rst resp in_ready", bus.in_ready, 1'b1);
    check4("rst resp result", bus.out_result, 4'h0);
    run_cmd("post rst resp add", OP_ADD, 4'h2, 4'h2, 1'b0, 1'b0);

    // back-to-back with in_valid and out_ready held high
    begin
      int idx  = 0;
      int nres = 0;
      int last = -1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (idx == 6) bus.in_valid = 1'b0;
        if (bus.out_valid === 1'b1) begin
          if (nres < 6) check4($sformatf("b2b result%0d", nres), bus.out_result, bexp[nres]);
          nres++;
        end
        if (bus.in_ready === 1'b1 && idx < 6) begin
          if (idx > 0) check4($sformatf("b2b gap%0d", idx), 4'(cyc - last), 4'd3);
          last       = cyc;
          bus.in_op  = bops[idx];
          bus.in_b   = bbs[idx];
          idx++;
        end
        @(negedge clk);
      end
      check4("b2b accepts", 4'(idx), 4'd6);
      check4("b2b results", 4'(nres), 4'd6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_acc_ctrl.md
ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 Parameter: none; data width fixed at 4 bits, opcode width fixed at 2 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  controller can accept a command.
REQ-006 in_op  input  2  opcode: 00 ADD, 01 AND, 10 LOAD, 11 CLR.
REQ-007 in_b  input  4  operand B.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_result  output  4  accumulator value after the command.
REQ-011 out_zero  output  1  out_result == 4'b0000.
REQ-012 out_carry  output  1  carry-out of last ADD (see Configuration).

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP; transitions: IDLE->EXEC on in_valid && in_ready; EXEC->RESP unconditionally; RESP->IDLE on out_ready.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in RESP.
REQ-015 On acceptance, in_op and in_b SHALL be captured into registers; in_op/in_b changes after acceptance SHALL have no effect.
REQ-016 In EXEC the accumulator acc SHALL update: ADD acc=acc+B (mod 16), AND acc=acc&B, LOAD acc=B, CLR acc=0.
REQ-017 Latency: command accepted in cycle N SHALL present out_valid=1 in cycle N+2.
REQ-018 out_result, out_zero, out_carry SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-019 Throughput: at most one command per 3 cycles; out_ready high in first RESP cycle SHALL return to IDLE next cycle.
REQ-020 acc SHALL persist across commands; only LOAD, CLR, ADD, AND and reset modify it.
REQ-021 in_valid while not in IDLE SHALL be ignored (no capture, no state change).

Reset
REQ-022 When rst_n=0 at a clock edge: state=IDLE, acc=0, out_result=0, out_zero=1, out_carry=0, out_valid=0, in_ready=1 from the next cycle.
REQ-023 Reset in EXEC or RESP SHALL abort the command; no result SHALL be presented for it.
REQ-024 Reset SHALL take priority over every simultaneous handshake.

Configuration
REQ-025 Macro ALU_ACC_CARRY_EN defined: ADD SHALL compute 5-bit sum, out_carry = sum[4]; non-ADD ops SHALL clear out_carry.
REQ-026 ALU_ACC_CARRY_EN undefined: out_carry port SHALL exist and be constant 0; ADD wraps mod 16 identically.

Structure
REQ-027 Package alu_acc_pkg SHALL hold opcode constants (OP_ADD, OP_AND, OP_LOAD, OP_CLR), data width constant, and FSM state typedef.
REQ-028 Combinational datapath SHALL be sub-module alu4_exec (inputs acc, B, op; outputs next_acc, carry); FSM and registers stay in alu_acc_ctrl.

Verification
REQ-029 Reset then LOAD B=4'h5 -> out_valid 2 cycles after accept, out_result=5, zero=0, carry=0.
REQ-030 LOAD 4'hC then ADD 4'h7 -> out_result=4'h3; carry=1 with ALU_ACC_CARRY_EN, 0 without.
REQ-031 LOAD 4'hA then AND 4'h6 -> out_result=4'h2; then CLR -> out_result=0, zero=1.
REQ-032 Hold out_ready=0 for 5 cycles in RESP with in_valid=1, in_op changing -> out_result stable, in_ready=0, no second capture.
REQ-033 rst_n=0 during EXEC of ADD 4'h1 -> no out_valid, acc=0; next ADD 4'h1 -> out_result=1.
REQ-034 Back-to-back commands with out_ready tied 1 -> accepts exactly every 3 cycles, results in order.
